johnson_sequence_monitor: RTL and testbench
===========================================

JOHNSON_SEQUENCE_MONITOR -- requirements
Module: johnson_sequence_monitor

Interface
REQ-001 Parameter LOCK_N, default 4, meaning the number of consecutive legal successor transitions required to declare lock (range 1..15) SHALL be provided.
REQ-002 Parameter ERR_W, default 8, meaning the width of the error counter SHALL be provided.
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  sample strobe; COUNT is sampled only on edges where EN=1.
REQ-006 COUNT  input  4  the 4-bit Johnson code from the upstream counter.
REQ-007 PHASE  output  8  one-hot decoded phase, registered.
REQ-008 PHASE_IDX  output  3  binary phase index 0..7, registered.
REQ-009 VALID  output  1  last sample was a legal code.
REQ-010 LOCKED  output  1  FSM is in state LOCKED.
REQ-011 ERR  output  1  one-cycle pulse flagging an illegal or out-of-sequence sample.
REQ-012 WRAP  output  1  one-cycle pulse on a legal 4'd1 -> 4'd0 sequence completion.
REQ-013 ERR_CNT  output  ERR_W  saturating count of ERR pulses.

Function
REQ-014 Legal code-to-index map SHALL be: 0->0, 8->1, 12->2, 14->3, 15->4, 7->5, 3->6, 1->7; the other 8 codes are illegal.
REQ-015 Successor of index i SHALL be (i+1) mod 8; index 7 -> 0 is the wrap transition.
REQ-016 All outputs SHALL be registered; the response to a sample SHALL appear on the edge on which EN=1 and COUNT are sampled (1-cycle latency from input to output).
REQ-017 On a legal sample: PHASE = 1 << index, PHASE_IDX = index, VALID=1.
REQ-018 On an illegal sample: PHASE=8'h00, VALID=0, PHASE_IDX holds its previous value, ERR=1.
REQ-019 On an edge with EN=0: PHASE, PHASE_IDX, VALID, FSM state and run count SHALL hold; ERR and WRAP SHALL be 0.
REQ-020 FSM states SHALL be UNLOCKED, TRACKING, LOCKED, with an internal run counter RUN (4 bits) and a stored reference index REF.
REQ-021 UNLOCKED: legal sample -> TRACKING, REF=index, RUN=0, ERR=0; illegal sample -> stay, ERR=1.
REQ-022 TRACKING: successor sample -> REF=index, RUN=RUN+1; if RUN+1 = LOCK_N -> LOCKED; legal non-successor (including a repeated code) -> ERR=1, REF=index, RUN=0, stay; illegal -> ERR=1, UNLOCKED.
REQ-023 LOCKED: successor -> stay, REF=index; legal non-successor -> ERR=1, TRACKING, REF=index, RUN=0; illegal -> ERR=1, UNLOCKED.
REQ-024 WRAP SHALL pulse only in TRACKING or LOCKED on a successor transition from REF=7 to index 0; never from UNLOCKED.
REQ-025 ERR_CNT SHALL increment by 1 on each edge where ERR is asserted and saturate at all-ones (no wrap to 0).
REQ-026 LOCKED SHALL be asserted on the same edge as the transition into state LOCKED and deasserted on the same edge as the transition out of it.

Reset
REQ-027 CLR=1 at a rising edge SHALL force UNLOCKED, RUN=0, REF=0, PHASE=0, PHASE_IDX=0, VALID=0, LOCKED=0, ERR=0, WRAP=0, ERR_CNT=0, regardless of EN/COUNT.
REQ-028 CLR SHALL take priority over EN; reset asserted mid-sequence or while LOCKED SHALL discard lock and the error count, with no ERR pulse generated.
REQ-029 The first sample after reset release SHALL be treated as the UNLOCKED case (no sequence check).

Verification
REQ-030 Reset, then EN=1 with COUNT stepping 0,8,12,14,15 -> PHASE 01,02,04,08,10; LOCKED=1 on the 5th sample edge (LOCK_N=4); ERR_CNT=0.
REQ-031 While locked, stepping 3,1,0 -> WRAP pulses exactly once on the 0 sample; PHASE=8'h01; LOCKED stays 1.
REQ-032 While locked, apply COUNT=4'd5 -> ERR=1, VALID=0, PHASE=0, PHASE_IDX unchanged, LOCKED=0, state UNLOCKED, ERR_CNT+1.
REQ-033 While locked at code 12, apply 12 again (repeat) -> ERR=1, LOCKED=0, state TRACKING; 4 further successors re-lock.
REQ-034 EN toggled 1,0,0,1 across a legal sequence -> EN=0 edges hold all outputs and pulse nothing; the sequence check bridges the gaps.
REQ-035 With ERR_W=2, force 5 illegal samples -> ERR_CNT reads 1,2,3,3,3; CLR=1 then returns it to 0 with all outputs at reset values.

Source files
------------

// File: rtl/johnson_sequence_monitor.sv
// Decodes a 4-bit Johnson count into a phase, checks that successive samples
// follow the Johnson order, and declares lock after LOCK_N clean successor steps.
//
// state       | meaning
// ST_UNLOCKED | no reference phase yet; the next legal sample seeds one
// ST_TRACKING | reference held, counting consecutive successor steps
// ST_LOCKED   | LOCK_N successor steps seen; any break drops lock
module johnson_sequence_monitor #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [3:0]       COUNT,
  output logic [7:0]       PHASE,
  output logic [2:0]       PHASE_IDX,
  output logic             VALID,
  output logic             LOCKED,
  output logic             ERR,
  output logic             WRAP,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_TRACKING = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [3:0] LOCK_CNT    = 4'(LOCK_N);

  logic [1:0] state, state_nxt;
  logic [3:0] run, run_nxt, run_inc;
  logic [2:0] ref_idx, ref_nxt, succ_idx;
  logic [2:0] idx;
  logic       legal, is_succ;
  logic       err_nxt, wrap_nxt;

  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (COUNT)
      4'd0:    idx = 3'd0;
      4'd8:    idx = 3'd1;
      4'd12:   idx = 3'd2;
      4'd14:   idx = 3'd3;
      4'd15:   idx = 3'd4;
      4'd7:    idx = 3'd5;
      4'd3:    idx = 3'd6;
      4'd1:    idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // 3-bit add wraps index 7 back to 0, giving the mod-8 successor for free
  assign succ_idx = ref_idx + 3'd1;
  assign is_succ  = (idx == succ_idx);
  assign run_inc  = run + 4'd1;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    ref_nxt   = ref_idx;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;
    if (EN) begin
      case (state)
        ST_UNLOCKED: begin
          if (legal) begin
            state_nxt = ST_TRACKING;
            ref_nxt   = idx;
            run_nxt   = 4'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        ST_TRACKING: begin
          if (!legal) begin
            err_nxt   = 1'b1;
            state_nxt = ST_UNLOCKED;
          end else if (is_succ) begin
            ref_nxt  = idx;
            run_nxt  = run_inc;
            wrap_nxt = (ref_idx == 3'd7);
            if (run_inc == LOCK_CNT) state_nxt = ST_LOCKED;
          end else begin
            err_nxt = 1'b1;
            ref_nxt = idx;
            run_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!legal) begin
            err_nxt   = 1'b1;
            state_nxt = ST_UNLOCKED;
          end else if (is_succ) begin
            ref_nxt  = idx;
            wrap_nxt = (ref_idx == 3'd7);
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_TRACKING;
            ref_nxt   = idx;
            run_nxt   = 4'd0;
          end
        end
        default: state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= ST_UNLOCKED;
      run       <= 4'd0;
      ref_idx   <= 3'd0;
      PHASE     <= 8'h00;
      PHASE_IDX <= 3'd0;
      VALID     <= 1'b0;
      LOCKED    <= 1'b0;
      ERR       <= 1'b0;
      WRAP      <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      state   <= state_nxt;
      run     <= run_nxt;
      ref_idx <= ref_nxt;
      LOCKED  <= (state_nxt == ST_LOCKED);
      ERR     <= err_nxt;
      WRAP    <= wrap_nxt;
      if (EN) begin
        if (legal) begin
          PHASE     <= 8'd1 << idx;
          PHASE_IDX <= idx;
          VALID     <= 1'b1;
        end else begin
          PHASE <= 8'h00;
          VALID <= 1'b0;
        end
      end
      if (err_nxt && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// Randomized and directed bench for johnson_sequence_monitor, checked against a
// sequence-level reference model; a second instance exercises a 2-bit error counter.
module tb_johnson_sequence_monitor;

  localparam int LOCK_N = 4;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] COUNT = 4'd0;

  logic [7:0] phase_a, phase_b;
  logic [2:0] idx_a, idx_b;
  logic       valid_a, valid_b, locked_a, locked_b, err_a, err_b, wrap_a, wrap_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // reference model
  int codes[8] = '{0, 8, 12, 14, 15, 7, 3, 1};
  int m_mode;     // 0 unlocked, 1 tracking, 2 locked
  int m_run, m_ref, m_phase, m_idx, m_valid, m_err, m_wrap, m_cnt, m_cnt2;

  johnson_sequence_monitor #(.LOCK_N(LOCK_N), .ERR_W(8)) u_dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .COUNT(COUNT),
    .PHASE(phase_a), .PHASE_IDX(idx_a), .VALID(valid_a), .LOCKED(locked_a),
    .ERR(err_a), .WRAP(wrap_a), .ERR_CNT(cnt_a)
  );

  johnson_sequence_monitor #(.LOCK_N(LOCK_N), .ERR_W(2)) u_dut_w2 (
    .CLK(CLK), .CLR(CLR), .EN(EN), .COUNT(COUNT),
    .PHASE(phase_b), .PHASE_IDX(idx_b), .VALID(valid_b), .LOCKED(locked_b),
    .ERR(err_b), .WRAP(wrap_b), .ERR_CNT(cnt_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input int code);
    for (int i = 0; i < 8; i++) if (codes[i] == code) return i;
    return -1;
  endfunction

  task automatic model_step(input logic c, input logic e, input logic [3:0] v);
    int li;
    if (c) begin
      m_mode = 0; m_run = 0; m_ref = 0; m_phase = 0; m_idx = 0;
      m_valid = 0; m_err = 0; m_wrap = 0; m_cnt = 0; m_cnt2 = 0;
      return;
    end
    m_err = 0;
    m_wrap = 0;
    if (!e) return;
    li = lookup(int'(v));
    if (li < 0) begin
      m_phase = 0; m_valid = 0; m_err = 1; m_mode = 0;
    end else begin
      m_phase = 1 << li; m_idx = li; m_valid = 1;
      if (m_mode == 0) begin
        m_mode = 1; m_ref = li; m_run = 0;
      end else if (li == (m_ref + 1) % 8) begin
        if (m_ref == 7) m_wrap = 1;
        m_ref = li;
        if (m_mode == 1) begin
          m_run++;
          if (m_run == LOCK_N) m_mode = 2;
        end
      end else begin
        m_err = 1; m_ref = li; m_run = 0; m_mode = 1;
      end
    end
    if (m_err == 1) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check_all();
    chk("phase", phase_a, m_phase);
    chk("phase_idx", idx_a, m_idx);
    chk("valid", valid_a, m_valid);
    chk("locked", locked_a, (m_mode == 2));
    chk("err", err_a, m_err);
    chk("wrap", wrap_a, m_wrap);
    chk("err_cnt", cnt_a, m_cnt);
    chk("w2_phase", phase_b, m_phase);
    chk("w2_locked", locked_b, (m_mode == 2));
    chk("w2_err_cnt", cnt_b, m_cnt2);
  endtask

  task automatic cyc(input logic c, input logic e, input logic [3:0] v);
    @(negedge CLK);
    CLR = c; EN = e; COUNT = v;
    @(posedge CLK);
    model_step(c, e, v);
    #1;
    check_all();
  endtask

  initial begin
    int exp_phase[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    int seq[5]       = '{0, 8, 12, 14, 15};
    int sat[5]       = '{1, 2, 3, 3, 3};
    int li;

    cyc(1, 1, 4'd5);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_locked", locked_a, 0);

    // lock-in from a clean start
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 4'(seq[i]));
      chk("lockin_phase", phase_a, exp_phase[i]);
      chk("lockin_locked", locked_a, (i == 4));
    end
    chk("lockin_cnt", cnt_a, 0);

    // wrap while locked
    cyc(0, 1, 4'd7); cyc(0, 1, 4'd3); cyc(0, 1, 4'd1);
    chk("prewrap", wrap_a, 0);
    cyc(0, 1, 4'd0);
    chk("wrap_pulse", wrap_a, 1);
    chk("wrap_phase", phase_a, 8'h01);
    chk("wrap_locked", locked_a, 1);
    cyc(0, 1, 4'd8);
    chk("wrap_once", wrap_a, 0);

    // repeat while locked at 12, then re-lock
    cyc(0, 1, 4'd12);
    cyc(0, 1, 4'd12);
    chk("repeat_err", err_a, 1);
    chk("repeat_locked", locked_a, 0);
    cyc(0, 1, 4'd14); cyc(0, 1, 4'd15); cyc(0, 1, 4'd7);
    chk("relock_pending", locked_a, 0);
    cyc(0, 1, 4'd3);
    chk("relock", locked_a, 1);

    // illegal code while locked
    cyc(0, 1, 4'd5);
    chk("illegal_err", err_a, 1);
    chk("illegal_idx", idx_a, 6);
    chk("illegal_cnt", cnt_a, 2);

    // EN gaps bridged by the sequence check
    cyc(1, 0, 4'd0);
    cyc(0, 1, 4'd0);
    cyc(0, 0, 4'd5);
    chk("gap_hold", phase_a, 8'h01);
    cyc(0, 0, 4'd12);
    chk("gap_err", err_a, 0);
    cyc(0, 1, 4'd8);
    chk("gap_bridge_err", err_a, 0);
    chk("gap_bridge_phase", phase_a, 8'h02);

    // 2-bit error counter saturation
    cyc(1, 1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 4'd9);
      chk("sat_cnt", cnt_b, sat[i]);
    end
    cyc(1, 1, 4'd9);
    chk("sat_clear", cnt_b, 0);
    chk("sat_clear_valid", valid_b, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       c, e;
      logic [3:0] v;
      int r;
      c = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 19);
      if (r < 15)      v = 4'(codes[(m_ref + 1) % 8]);
      else if (r < 17) v = 4'(codes[$urandom_range(0, 7)]);
      else             v = 4'($urandom_range(0, 15));
      cyc(c, e, v);
    end
    li = lookup(int'(COUNT));
    chk("final_lookup_range", (li >= -1 && li < 8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
